apb3_requester_arbiter: RTL and testbench

- Shares one APB3 completer port between NumRequesters simple command sources (CPU bridge, DMA, test sequencer) using round-robin arbitration.
- Latches the winning command and sequences the APB3 SETUP/ACCESS phases, including wait states.
- Returns read data and error status to the granted requester.
- Sits between co-simulation requesters and a renode_apb3_if-connected completer.

---
 rtl/apb3_arb_pkg.sv | 47 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/apb3_requester_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb3_requester_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_arb_pkg.sv
// rtl/apb3_arb_pkg.sv - shared types and round-robin pick function for the APB3 requester arbiter
//
// Purpose : FSM state enum, latched command struct and the rr_pick helper
//           used by rr_arbiter and apb3_requester_arbiter.
// Ports   : none (package).
package apb3_arb_pkg;

  localparam int MaxRequesters = 8;
  localparam int MaxAddrWidth  = 32;
  localparam int MaxDataWidth  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Sized for the widest legal configuration; the top uses the low bits.
  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic                    write;
    logic [MaxDataWidth-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First valid index at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MaxRequesters-1:0] valid,
                                    input logic [2:0]               ptr,
                                    input int                       n);
    pick_t      r;
    logic [2:0] i;
    r = '0;
    for (int k = 0; k < MaxRequesters; k++) begin
      i = 3'((int'(ptr) + k) % n);
      if ((k < n) && !r.found && valid[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick with registered rotating priority pointer
//
// Purpose : combinational grant from req_valid starting at rr_ptr; the
//           pointer moves past the winner when the caller accepts (advance).
// Ports   : pclk, presetn (async active-low), req_valid[N], advance,
//           grant_found, grant_idx[2:0].
import apb3_arb_pkg::*;

module rr_arbiter #(
  parameter int NumRequesters = 2
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [NumRequesters-1:0] req_valid,
  input  logic                     advance,
  output logic                     grant_found,
  output logic [2:0]               grant_idx
);

  logic [2:0]               rr_ptr_q;
  logic [MaxRequesters-1:0] valid_ext;
  pick_t                    pick;

  always_comb begin
    valid_ext                    = '0;
    valid_ext[NumRequesters-1:0] = req_valid;
    pick                         = rr_pick(valid_ext, rr_ptr_q, NumRequesters);
  end

  assign grant_found = pick.found;
  assign grant_idx   = pick.idx;

  // With one requester the wrap test always yields 0, so the pointer stays 0.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rr_ptr_q <= 3'd0;
    end else if (advance && pick.found) begin
      rr_ptr_q <= ((int'(pick.idx) + 1) >= NumRequesters) ? 3'd0 : pick.idx + 3'd1;
    end
  end

endmodule

// File: rtl/apb3_requester_arbiter.sv
// rtl/apb3_requester_arbiter.sv - shares one APB3 completer between round-robin arbitrated requesters
//
// Purpose : grants one requester in IDLE, latches its command, runs the APB3
//           SETUP/ACCESS sequence and returns rdata/error with a one-cycle
//           rsp_valid pulse to the owner.
// Ports   : pclk, presetn (async active-low);
//           requester side req_valid/req_ready/req_addr/req_write/req_wdata,
//           rsp_valid/rsp_rdata/rsp_error;
//           APB side paddr/pselx/penable/pwrite/pwdata, pready/prdata/pslverr.
// Macro   : APB3_ARB_TIMEOUT_EN aborts ACCESS after TimeoutCycles wait states.
import apb3_arb_pkg::*;

module apb3_requester_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic [NumRequesters-1:0]           req_valid,
  output logic [NumRequesters-1:0]           req_ready,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr,
  input  logic [NumRequesters-1:0]           req_write,
  input  logic [NumRequesters*DataWidth-1:0] req_wdata,
  output logic [NumRequesters-1:0]           rsp_valid,
  output logic [DataWidth-1:0]               rsp_rdata,
  output logic                               rsp_error,
  output logic [AddressWidth-1:0]            paddr,
  output logic                               pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [DataWidth-1:0]               pwdata,
  input  logic                               pready,
  input  logic [DataWidth-1:0]               prdata,
  input  logic                               pslverr
);

  state_t                   state_q, state_d;
  cmd_t                     cmd_q, cmd_sel;
  logic [2:0]               owner_q;
  logic [NumRequesters-1:0] owner_onehot;
  logic                     grant_found;
  logic [2:0]               grant_idx;
  logic                     handshake, complete, abort;
  logic [NumRequesters-1:0] rsp_valid_q;
  logic [DataWidth-1:0]     rsp_rdata_q;
  logic                     rsp_error_q;
  logic                     unused_cmd;

  rr_arbiter #(.NumRequesters(NumRequesters)) u_rr (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .advance     (handshake),
    .grant_found (grant_found),
    .grant_idx   (grant_idx)
  );

  // Mux the granted requester's command; ready is gated by presetn so every
  // output reads 0 while reset is held.
  always_comb begin
    cmd_sel      = '0;
    req_ready    = '0;
    owner_onehot = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      owner_onehot[i] = (owner_q == 3'(i));
      if (grant_idx == 3'(i)) begin
        cmd_sel.addr  = MaxAddrWidth'(req_addr[i*AddressWidth +: AddressWidth]);
        cmd_sel.write = req_write[i];
        cmd_sel.wdata = MaxDataWidth'(req_wdata[i*DataWidth +: DataWidth]);
        req_ready[i]  = presetn && grant_found && (state_q == IDLE);
      end
    end
  end

  assign handshake = (state_q == IDLE) && grant_found;
  assign complete  = (state_q == ACCESS) && pready;

`ifdef APB3_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  // pready on the limit cycle wins: abort only fires with pready low.
  assign abort = (state_q == ACCESS) && !pready && (wait_cnt_q == 32'(TimeoutCycles - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pselx   = 1'b0;
    penable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) state_d = SETUP;
      end
      SETUP: begin
        pselx   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        pselx   = 1'b1;
        penable = 1'b1;
        if (complete || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      owner_q     <= 3'd0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (handshake) begin
        cmd_q   <= cmd_sel;
        owner_q <= grant_idx;
      end
      if (complete) begin
        rsp_valid_q <= owner_onehot;
        rsp_rdata_q <= cmd_q.write ? '0 : prdata;
        rsp_error_q <= pslverr;
      end else if (abort) begin
        rsp_valid_q <= owner_onehot;
        rsp_rdata_q <= '0;
        rsp_error_q <= 1'b1;
      end
    end
  end

  // Latch holds across IDLE so paddr/pwdata stay stable between transfers.
  assign paddr      = cmd_q.addr[AddressWidth-1:0];
  assign pwdata     = cmd_q.wdata[DataWidth-1:0];
  assign pwrite     = cmd_q.write;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;
  assign unused_cmd = ^{cmd_q.addr, cmd_q.wdata};

endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// tb/tb_apb3_requester_arbiter.sv - directed self-checking bench for apb3_requester_arbiter
module tb_apb3_requester_arbiter;

  localparam int NR = 2;
  localparam int AW = 20;
  localparam int DW = 32;

  logic             pclk = 1'b0;
  logic             presetn = 1'b0;
  logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, pwdata, prdata;
  logic             rsp_error, pselx, penable, pwrite, pready, pslverr;
  logic [AW-1:0]    paddr;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb3_requester_arbiter #(
    .NumRequesters (NR),
    .AddressWidth  (AW),
    .DataWidth     (DW),
    .TimeoutCycles (8)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  initial begin
    logic [1:0]    exp_own;
    logic [AW-1:0] exp_addr;
    int            n;

    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;

    // Reset state
    #12;
    check("rst_psel", pselx, 0);
    check("rst_pen", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    presetn = 1'b1;
    tick;

    // Single read, zero wait states
    set_req(0, 1'b1, 1'b0, 20'h00010, 32'h0);
    pready = 1'b1; prdata = 32'hDEADBEEF;
    #1;
    check("rd_ready_t0", req_ready, 2'b01);
    tick;
    check("rd_setup_psel", pselx, 1);
    check("rd_setup_pen", penable, 0);
    check("rd_setup_addr", paddr, 20'h00010);
    check("rd_ready_busy", req_ready, 0);
    req_valid[0] = 1'b0;
    tick;
    check("rd_access_pen", penable, 1);
    check("rd_access_rsp", rsp_valid, 0);
    tick;
    check("rd_rsp_valid", rsp_valid, 2'b01);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_rsp_error", rsp_error, 0);
    check("rd_idle_psel", pselx, 0);

    // Write with 3 wait states
    pready = 1'b0; prdata = 32'h55555555;
    set_req(1, 1'b1, 1'b1, 20'h00020, 32'h12345678);
    #1;
    check("wr_ready_t0", req_ready, 2'b10);
    tick;
    check("wr_setup_pen", penable, 0);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 32'h12345678);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("wr_access_pen", penable, 1);
      check("wr_access_addr", paddr, 20'h00020);
      check("wr_access_wdata", pwdata, 32'h12345678);
      check("wr_access_rsp", rsp_valid, 0);
      pready = (k == 3);
    end
    tick;
    check("wr_rsp_valid", rsp_valid, 2'b10);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_rsp_error", rsp_error, 0);
    check("wr_idle_pen", penable, 0);
    check("wr_idle_paddr", paddr, 20'h00020);
    pready = 1'b0;
    tick;
    check("wr_rsp_once", rsp_valid, 0);

    // Contention: both requesters continuously valid
    pready = 1'b1;
    set_req(0, 1'b1, 1'b0, 20'h00100, 32'h0);
    set_req(1, 1'b1, 1'b0, 20'h00200, 32'h0);
    for (int t = 0; t < 4; t++) begin
      exp_own  = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 20'h00100 : 20'h00200;
      prdata   = 32'h0000A000 + 32'(t);
      #1;
      check("cont_ready", req_ready, exp_own);
      tick;
      check("cont_addr", paddr, exp_addr);
      tick;
      tick;
      check("cont_rsp", rsp_valid, exp_own);
      check("cont_rdata", rsp_rdata, 32'h0000A000 + 32'(t));
    end
    req_valid = '0;

    // Error completion on a read
    tick;
    set_req(1, 1'b1, 1'b0, 20'h00300, 32'h0);
    prdata = 32'hCAFEF00D; pslverr = 1'b1; pready = 1'b1;
    #1;
    check("err_ready", req_ready, 2'b10);
    tick;
    req_valid[1] = 1'b0;
    tick;
    tick;
    check("err_rsp_valid", rsp_valid, 2'b10);
    check("err_rsp_error", rsp_error, 1);
    check("err_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    pslverr = 1'b0;

    // Reset while waiting in ACCESS
    tick;
    pready = 1'b0;
    set_req(0, 1'b1, 1'b0, 20'h00400, 32'h0);
    set_req(1, 1'b1, 1'b0, 20'h00500, 32'h0);
    #1;
    check("rstx_ready", req_ready, 2'b01);
    tick;
    tick;
    tick;
    check("rstx_in_access", penable, 1);
    presetn = 1'b0;
    #1;
    check("rstx_psel", pselx, 0);
    check("rstx_pen", penable, 0);
    check("rstx_paddr", paddr, 0);
    check("rstx_pwrite", pwrite, 0);
    check("rstx_pwdata", pwdata, 0);
    check("rstx_req_ready", req_ready, 0);
    check("rstx_rsp_valid", rsp_valid, 0);
    check("rstx_rsp_error", rsp_error, 0);
    check("rstx_rsp_rdata", rsp_rdata, 0);
    tick;
    check("rstx_no_rsp", rsp_valid, 0);
    presetn = 1'b1;
    #1;
    check("rstx_ptr_zero", req_ready, 2'b01);
    pready = 1'b1;
    tick;
    req_valid = '0;
    tick;
    tick;
    check("rstx_after_rsp", rsp_valid, 2'b01);

`ifdef APB3_ARB_TIMEOUT_EN
    // Timeout abort after TimeoutCycles ACCESS cycles
    tick;
    pready = 1'b0;
    set_req(1, 1'b1, 1'b0, 20'h00600, 32'h0);
    #1;
    check("to_ready", req_ready, 2'b10);
    tick;
    req_valid[1] = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (penable) n++;
      else break;
    end
    check("to_access_cycles", n, 8);
    check("to_rsp_valid", rsp_valid, 2'b10);
    check("to_rsp_error", rsp_error, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel_drop", pselx, 0);
    set_req(0, 1'b1, 1'b0, 20'h00700, 32'h0);
    prdata = 32'h00000077; pready = 1'b1;
    #1;
    check("to_next_ready", req_ready, 2'b01);
    tick;
    req_valid[0] = 1'b0;
    tick;
    tick;
    check("to_next_rsp", rsp_valid, 2'b01);
    check("to_next_error", rsp_error, 0);
    check("to_next_rdata", rsp_rdata, 32'h00000077);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
